// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcode encoding and control FSM states.
package alu_mc_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_NOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_PASSB = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_XOR  = 4'd11,
        ALU_MULU = 4'd12,
        ALU_DIVU = 4'd13
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Opcodes that go through the iterative multiply/divide datapath.
    function automatic logic is_iter_op(input logic [3:0] f);
        return (f == ALU_MULU) || (f == ALU_DIVU);
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// hi/lo present the value after the current iteration so the caller can capture on done.
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic              active;
    logic              op_div;
    logic [CNTW-1:0]   cnt;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  quo;
    logic [WIDTH-1:0]  opnd;

    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    shifted;
    logic              fits;
    logic [WIDTH-1:0]  rem_sub;
    logic [WIDTH-1:0]  acc_nxt;
    logic [WIDTH-1:0]  quo_nxt;

    // acc is the high half (product high / partial remainder), quo the low half
    // (multiplier being consumed / dividend shifting out while quotient shifts in).
    always_comb begin
        mul_sum = {1'b0, acc} + {1'b0, (quo[0] ? opnd : '0)};
        shifted = {acc, quo[WIDTH-1]};
        fits    = shifted >= {1'b0, opnd};
        rem_sub = shifted[WIDTH-1:0] - opnd;
        acc_nxt = '0;
        quo_nxt = '0;
        if (op_div) begin
            if (fits) begin
                acc_nxt = rem_sub;
                quo_nxt = {quo[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = shifted[WIDTH-1:0];
                quo_nxt = {quo[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt = mul_sum[WIDTH:1];
            quo_nxt = {mul_sum[0], quo[WIDTH-1:1]};
        end
    end

    assign done = active && (cnt == CNTW'(WIDTH - 1));
    assign hi   = acc_nxt;
    assign lo   = quo_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            op_div <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            quo    <= '0;
            opnd   <= '0;
        end else if (start) begin
            active <= 1'b1;
            op_div <= op_sel;
            cnt    <= '0;
            acc    <= '0;
            quo    <= op_sel ? a : b;
            opnd   <= op_sel ? b : a;
        end else if (active) begin
            acc <= acc_nxt;
            quo <= quo_nxt;
            cnt <= cnt + CNTW'(1);
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: registered single-cycle ops plus iterative MULU/DIVU,
// with valid/ready on both sides so control can stall on long operations.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH),
    parameter int CNTW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic             zero_flag,
    output logic             ovf_flag,
    output logic             div0_flag
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // The producer holds its data stable while valid is high and ready is low.

    state_e            state;
    state_e            state_nxt;
    logic              accept;
    logic              long_op;
    logic              iter_start;
    logic              iter_done;
    logic [WIDTH-1:0]  iter_hi;
    logic [WIDTH-1:0]  iter_lo;
    logic              div0_pend;

    logic [WIDTH-1:0]  sum;
    logic [WIDTH-1:0]  diff;
    logic [SHW-1:0]    shamt;
    logic [WIDTH-1:0]  alu_out;
    logic              alu_ovf;
    logic              alu_legal;

    assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign out_valid = (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign long_op   = is_iter_op(func);

    always_comb begin
        sum       = a + b;
        diff      = a - b;
        shamt     = b[SHW-1:0];
        alu_out   = '0;
        alu_ovf   = 1'b0;
        alu_legal = 1'b1;
        case (alu_op_e'(func))
            ALU_ADD: begin
                alu_out = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_out = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:   alu_out = a & b;
            ALU_OR:    alu_out = a | b;
            ALU_NOR:   alu_out = ~(a | b);
            ALU_SLT:   alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_PASSB: alu_out = b;
            ALU_SLTU:  alu_out = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SLL:   alu_out = a << shamt;
            ALU_SRL:   alu_out = a >> shamt;
            ALU_SRA:   alu_out = $unsigned($signed(a) >>> shamt);
            ALU_XOR:   alu_out = a ^ b;
            // Illegal codes land here; MULU/DIVU also do, but their result comes from the iterator.
            default:   alu_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        iter_start = accept && long_op;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = long_op ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (iter_done) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (accept) begin
                    state_nxt = long_op ? S_BUSY : S_DONE;
                end else if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            hi        <= '0;
            zero_flag <= 1'b0;
            ovf_flag  <= 1'b0;
            div0_flag <= 1'b0;
            div0_pend <= 1'b0;
        end else begin
            if (accept) begin
                div0_pend <= (func == ALU_DIVU) && (b == '0);
            end
            if (accept && !long_op) begin
                out       <= alu_out;
                hi        <= '0;
                zero_flag <= alu_legal && (alu_out == '0);
                ovf_flag  <= alu_ovf;
                div0_flag <= 1'b0;
            end else if (iter_done) begin
                out       <= iter_lo;
                hi        <= iter_hi;
                zero_flag <= (iter_lo == '0);
                ovf_flag  <= 1'b0;
                div0_flag <= div0_pend;
            end
        end
    end

    alu_mc_iter #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (iter_start),
        .op_sel (func == ALU_DIVU),
        .a      (a),
        .b      (b),
        .done   (iter_done),
        .hi     (iter_hi),
        .lo     (iter_lo)
    );

endmodule
